// File: rtl/result_fifo.sv
// Result word buffer between the pulse timing controller and the AXI read port.
// Edge-triggered capture, circular storage, FWFT output, sticky overflow tracking.
module result_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  init,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] dropped,
    input  logic                  clear_overflow
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp, r_rp;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic [DROP_WIDTH-1:0] r_dropped;
    logic                  r_wr_req_d;

    logic w_push, w_pop, w_full, w_wr_en, w_drop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = wr_req & ~r_wr_req_d;
    assign w_pop   = rd_valid & rd_ready & ~init;
    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    assign w_wr_en = w_push & (~w_full | w_pop) & ~init;
    assign w_drop  = w_push & w_full & ~w_pop & ~init;

    assign rd_valid = (r_count != '0);
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;
    assign rd_data  = r_mem[r_rp];

    always_ff @(posedge clock) begin
        if (w_wr_en)
            r_mem[r_wp] <= wr_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
            r_wr_req_d <= 1'b1;
        end else begin
            r_wr_req_d <= wr_req;
            if (init) begin
                r_wp       <= '0;
                r_rp       <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_dropped  <= '0;
            end else begin
                if (w_wr_en)
                    r_wp <= r_wp + 1'b1;
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
                if (w_wr_en && !w_pop)
                    r_count <= r_count + 1'b1;
                else if (!w_wr_en && w_pop)
                    r_count <= r_count - 1'b1;
                // A drop in the same cycle as a clear restarts the count at one.
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (clear_overflow)
                        r_dropped <= DROP_WIDTH'(1);
                    else if (!(&r_dropped))
                        r_dropped <= r_dropped + 1'b1;
                end else if (clear_overflow) begin
                    r_overflow <= 1'b0;
                    r_dropped  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_result_fifo.sv
// Bench for result_fifo: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_result_fifo;
    localparam int DW = 32;
    localparam int DL = 4;
    localparam int DEPTH = 16;
    localparam int DRW = 16;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          init = 1'b0;
    logic          wr_req = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DL:0]   count;
    logic          full;
    logic          overflow;
    logic [DRW-1:0] dropped;
    logic          clear_overflow = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    result_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .DROP_WIDTH(DRW)) dut (
        .clock(clock), .resetn(resetn), .init(init), .wr_req(wr_req),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .count(count), .full(full), .overflow(overflow),
        .dropped(dropped), .clear_overflow(clear_overflow)
    );

    always #5 clock = ~clock;

    // Reference model: contents as a queue, status as plain integers.
    logic [DW-1:0] m_q[$];
    bit            m_ovf;
    int            m_drop;
    bit            m_req_d;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_ovf   = 0;
            m_drop  = 0;
            m_req_d = 1;
        end else begin
            bit push, pop, lost;
            push    = wr_req && !m_req_d;
            pop     = (m_q.size() != 0) && rd_ready;
            m_req_d = wr_req;
            if (init) begin
                m_q.delete();
                m_ovf  = 0;
                m_drop = 0;
            end else begin
                lost = push && (m_q.size() == DEPTH) && !pop;
                if (pop) void'(m_q.pop_front());
                if (push && !lost) m_q.push_back(wr_data);
                if (lost) begin
                    m_ovf  = 1;
                    m_drop = clear_overflow ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
                end else if (clear_overflow) begin
                    m_ovf  = 0;
                    m_drop = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("m_valid", {31'd0, rd_valid}, {31'd0, m_q.size() != 0});
        chk("m_count", {27'd0, count}, DW'(m_q.size()));
        chk("m_full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
        chk("m_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        chk("m_drop", {16'd0, dropped}, DW'(m_drop));
        if (m_q.size() != 0) chk("m_data", rd_data, m_q[0]);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_data = d;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    logic [DW-1:0] exp_v;

    initial begin
        // Request held high through reset release must not push.
        #12 resetn = 1'b1;
        #1;
        repeat (10) tick();
        chk("hold_cnt", {27'd0, count}, 32'd0);
        chk("hold_vld", {31'd0, rd_valid}, 32'd0);
        wr_req = 1'b0;
        tick();

        wr_data = 32'hDEADBEEF;
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
        chk("one_vld", {31'd0, rd_valid}, 32'd1);
        chk("one_data", rd_data, 32'hDEADBEEF);
        chk("one_cnt", {27'd0, count}, 32'd1);
        tick();
        pop_n(1);
        chk("pop_cnt", {27'd0, count}, 32'd0);
        chk("pop_vld", {31'd0, rd_valid}, 32'd0);

        for (int i = 0; i < 16; i++) push(DW'(i));
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_cnt", {27'd0, count}, 32'd16);
        push(32'h99);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_drop", {16'd0, dropped}, 32'd1);
        chk("ovf_cnt", {27'd0, count}, 32'd16);

        // Push with simultaneous pop while full is accepted.
        wr_data = 32'hAA; wr_req = 1'b1; rd_ready = 1'b1;
        tick();
        wr_req = 1'b0; rd_ready = 1'b0;
        tick();
        chk("pp_cnt", {27'd0, count}, 32'd16);
        chk("pp_head", rd_data, 32'd1);
        chk("pp_ovf", {31'd0, overflow}, 32'd1);
        chk("pp_drop", {16'd0, dropped}, 32'd1);

        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_v = (i < 15) ? DW'(i + 1) : 32'hAA;
            chk("drain", rd_data, exp_v);
            tick();
        end
        rd_ready = 1'b0;
        chk("drain_vld", {31'd0, rd_valid}, 32'd0);

        for (int i = 0; i < 5; i++) push(32'h100 + DW'(i));
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("wrap", rd_data, 32'h100 + DW'(i));
            tick();
        end
        rd_ready = 1'b0;

        wr_data = 32'h55; wr_req = 1'b1;
        repeat (5) tick();
        wr_req = 1'b0;
        tick();
        chk("held_cnt", {27'd0, count}, 32'd1);
        pop_n(1);

        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_drop", {16'd0, dropped}, 32'd0);

        for (int i = 0; i < 16; i++) push(32'h200 + DW'(i));
        push(32'h77);
        wr_data = 32'h78; wr_req = 1'b1; clear_overflow = 1'b1;
        tick();
        wr_req = 1'b0; clear_overflow = 1'b0;
        chk("clrdrop_ovf", {31'd0, overflow}, 32'd1);
        chk("clrdrop_cnt", {16'd0, dropped}, 32'd1);
        tick();
        push(32'h79);
        chk("drop2", {16'd0, dropped}, 32'd2);

        pop_n(9);
        chk("seven", {27'd0, count}, 32'd7);
        wr_req = 1'b1; init = 1'b1;
        tick();
        init = 1'b0;
        repeat (3) tick();
        chk("init_cnt", {27'd0, count}, 32'd0);
        chk("init_ovf", {31'd0, overflow}, 32'd0);
        chk("init_drop", {16'd0, dropped}, 32'd0);
        chk("init_vld", {31'd0, rd_valid}, 32'd0);
        wr_req = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) push(32'h300 + DW'(i));
        chk("pre_rst_full", {31'd0, full}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_vld", {31'd0, rd_valid}, 32'd0);
        chk("rst_cnt", {27'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_drop", {16'd0, dropped}, 32'd0);
        repeat (2) tick();
        #2 resetn = 1'b1;
        repeat (3) tick();
        push(32'h1234);
        chk("post_rst", rd_data, 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/result_fifo.md
# result_fifo

Buffers 32-bit result words (DDS readback, SPI readback, loop-back data) from the pulse timing controller until the AXI slave's read port drains them. Each rising edge of the controller's result write request captures exactly one word. Words are stored in a circular buffer and presented to the bus side as a first-word-fall-through valid/ready stream. Overflow is detected, counted and reported as sticky status.

## Interface
Parameters:
- `DATA_WIDTH`, 32, result word width.
- `DEPTH_LOG2`, 4, buffer depth is 2^DEPTH_LOG2 words (default 16).
- `DROP_WIDTH`, 16, width of the saturating dropped-word counter.

Ports:
- `clock` in 1: single clock for the whole block.
- `resetn` in 1: asynchronous, active-low reset.
- `init` in 1: synchronous clear; same meaning as the controller's sequence-start init.
- `wr_req` in 1: result write request, edge-detected (from `rFIFO_WrReq`).
- `wr_data` in DATA_WIDTH: result word (from `rFIFO_data`).
- `rd_data` out DATA_WIDTH: head word, valid when `rd_valid` is high.
- `rd_valid` out 1: buffer non-empty.
- `rd_ready` in 1: consumer accepts the head word.
- `count` out DEPTH_LOG2+1: number of stored words, 0 to 2^DEPTH_LOG2.
- `full` out 1: `count` equals 2^DEPTH_LOG2.
- `overflow` out 1: sticky; at least one word was dropped.
- `dropped` out DROP_WIDTH: number of dropped words, saturating.
- `clear_overflow` in 1: single-cycle pulse; clears `overflow` and `dropped`.

## Operation
- Edge detect: a 1-bit register `wr_req_d` holds last cycle's `wr_req`. A push event occurs in any cycle where `wr_req & ~wr_req_d`. `wr_data` is sampled in that same cycle.
- `wr_req_d` resets to 1, so a request held high through reset release generates no push.
- During `init`, `wr_req_d` follows `wr_req`, so a request held high across init release also generates no push.
- Storage: memory of 2^DEPTH_LOG2 words, write pointer `wp`, read pointer `rp`, each DEPTH_LOG2 bits and wrapping modulo depth. `count` is a separate register.
- Pop event: `rd_valid & rd_ready`. `rd_data` is read combinationally as mem[`rp`].
- Push only (not full): write mem[`wp`], increment `wp`, `count` +1.
- Pop only: increment `rp`, `count` -1.
- Push and pop together: both pointers advance and `count` is unchanged. This is allowed when full; the push is accepted.
- Push while full with no pop: the word is discarded, `overflow` is set to 1, `dropped` +1 (held at all-ones when saturated). Pointers and `count` are unchanged.
- `clear_overflow`: `overflow` goes to 0 and `dropped` to 0 on the next edge. If a drop occurs in the same cycle, the drop wins: `overflow`=1 and `dropped`=1.
- `init`: on the next edge, `wp`, `rp`, `count`, `overflow` and `dropped` clear to 0. Any push or pop in that cycle is ignored.
- Reset (asynchronous, mid-operation included): `wp`=`rp`=0, `count`=0, `overflow`=0, `dropped`=0, `wr_req_d`=1. Memory contents are not reset.
- Output reset values: `rd_valid`=0, `full`=0, `count`=0, `overflow`=0, `dropped`=0, `rd_data`=don't-care.

## Timing
- Push latency: a push event in cycle N makes the word visible at the head in cycle N+1 if the buffer was empty. `rd_valid`=1 and `count` updates in N+1.
- Pop: `rd_ready` high in a cycle with `rd_valid` high consumes the word at that edge. The next word is presented in the following cycle.
- Throughput: one push and one pop per cycle maximum. Back-to-back pushes need `wr_req` to toggle, so the maximum push rate is one word per 2 cycles.
- `rd_valid`, `full` and `count` are registered or derived only from registered state, with no combinational path from `rd_ready`.
- `overflow` and `dropped` update at the edge following the dropped push.

## Test plan
- Reset with `wr_req`=1 held, release `resetn`, hold `wr_req` high 10 cycles -> `count`=0, `rd_valid`=0.
- Pulse `wr_req` (1 cycle) with `wr_data`=0xDEADBEEF, `rd_ready`=0 -> `rd_valid`=1 next cycle, `rd_data`=0xDEADBEEF, `count`=1. Assert `rd_ready` for 1 cycle -> `count`=0, `rd_valid`=0.
- Push 0..15 into a 16-deep buffer -> `full`=1, `count`=16. Push 0x99 -> `overflow`=1, `dropped`=1, count still 16. Drain 16 pops -> values 0..15 in order, with pointer wrap checked by pushing 5 more and reading them back.
- When full, push 0xAA with a simultaneous pop -> head 0 popped, 0xAA stored last, `count`=16, `overflow` unchanged.
- Hold `wr_req` high for 5 cycles -> exactly one word stored.
- `clear_overflow` in the same cycle as a drop -> `overflow`=1, `dropped`=1. Then `init` with `count`=7 -> `count`=0, `overflow`=0, `dropped`=0, `rd_valid`=0. Assert `resetn`=0 mid-stream -> all outputs at reset values immediately.
